// File: rtl/instr_fetch_if.sv
// Fetch-stage bundle: instruction memory request/response
// plus the decoded instruction handshake toward control.
interface instr_fetch_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        pc_src;
  logic [31:0] branch_target;
  logic        fetch_fault;

  modport master (
    output imem_req_valid, imem_addr,
    output instr_valid, instr, opcode,
    output funct3, funct7, rd, rs1, rs2,
    output pc, pc_plus4, fetch_fault,
    input  imem_req_ready, imem_resp_valid,
    input  imem_rdata, instr_ready,
    input  pc_src, branch_target
  );

  modport slave (
    input  imem_req_valid, imem_addr,
    input  instr_valid, instr, opcode,
    input  funct3, funct7, rd, rs1, rs2,
    input  pc, pc_plus4, fetch_fault,
    output imem_req_ready, imem_resp_valid,
    output imem_rdata, instr_ready,
    output pc_src, branch_target
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, single-outstanding imem
// request, instruction buffer and redirect on consume.
module instr_fetch #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          reset,
  instr_fetch_if.master bus
);
  typedef enum logic [1:0] {
    REQ, WAIT, HOLD, FAULT
  } state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] next_pc;
  logic        consume;
  logic        misaligned;

  assign consume = bus.instr_valid
                && bus.instr_ready;
  assign next_pc = bus.pc_src
                 ? bus.branch_target
                 : bus.pc_plus4;
  // a bad target freezes the stage with pc kept
  assign misaligned = bus.pc_src
    && (bus.branch_target[1:0] != 2'b00);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    unique case (state_q)
      REQ: begin
        if (bus.imem_req_ready)
          state_d = WAIT;
      end
      WAIT: begin
        if (bus.imem_resp_valid) begin
          instr_d = bus.imem_rdata;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (consume) begin
          if (misaligned) begin
            state_d = FAULT;
          end else begin
            pc_d    = next_pc;
            state_d = REQ;
          end
        end
      end
      FAULT: state_d = FAULT;
      default: state_d = REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= REQ;
      pc_q    <= RESET_VECTOR;
      instr_q <= NOP;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign bus.imem_req_valid = (state_q == REQ)
                            && !reset;
  assign bus.imem_addr   = pc_q;
  assign bus.instr_valid = (state_q == HOLD);
  assign bus.fetch_fault = (state_q == FAULT);
  assign bus.instr       = instr_q;
  assign bus.pc          = pc_q;
  assign bus.pc_plus4    = pc_q + 32'd4;
  assign bus.opcode      = instr_q[6:0];
  assign bus.rd          = instr_q[11:7];
  assign bus.funct3      = instr_q[14:12];
  assign bus.rs1         = instr_q[19:15];
  assign bus.rs2         = instr_q[24:20];
  assign bus.funct7      = instr_q[31:25];
endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed wrap/branch/fault run on
// one instance, randomized scoreboard run on another.
module tb_instr_fetch;
  localparam logic [31:0] RV0 = 32'h0000_0000;
  localparam logic [31:0] RV1 = 32'hFFFF_FFFC;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_t;

  logic clk = 1'b0;
  logic rst0, rst1;
  always #5 clk = ~clk;

  instr_fetch_if b0();
  instr_fetch_if b1();

  instr_fetch #(.RESET_VECTOR(RV0)) u0 (
    .clk(clk), .reset(rst0), .bus(b0)
  );
  instr_fetch #(.RESET_VECTOR(RV1)) u1 (
    .clk(clk), .reset(rst1), .bus(b1)
  );

  int n_pass = 0;
  int n_total = 0;
  int delivered = 0;

  exp_t        ins_q[$];
  logic [31:0] req_q[$];
  bit          fault_q[$];
  logic [31:0] model_pc;
  bit          model_fault;
  bit          allow_fault = 0;

  function automatic logic [31:0] mem_word(
    input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h",
                  nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // memory model for u0, one request in flight
  logic        m_out = 0;
  logic [31:0] m_addr = 0;
  initial begin
    logic acc, got;
    logic [31:0] a;
    b0.imem_req_ready  = 0;
    b0.imem_resp_valid = 0;
    b0.imem_rdata      = 0;
    forever begin
      @(negedge clk);
      acc = b0.imem_req_valid && b0.imem_req_ready;
      got = b0.imem_resp_valid && m_out;
      a   = b0.imem_addr;
      @(posedge clk);
      #1;
      if (rst0) begin
        m_out = 0;
        b0.imem_req_ready  = 0;
        b0.imem_resp_valid = 0;
      end else begin
        if (got) m_out = 0;
        if (acc) begin
          m_out  = 1;
          m_addr = a;
        end
        b0.imem_req_ready = 1'($urandom_range(0, 1));
        b0.imem_rdata = $urandom;
        b0.imem_resp_valid = 0;
        if (m_out && $urandom_range(0, 2) == 0) begin
          b0.imem_resp_valid = 1;
          b0.imem_rdata = mem_word(m_addr);
        end else if (!m_out
                     && $urandom_range(0, 4) == 0) begin
          b0.imem_resp_valid = 1;
        end
      end
    end
  end

  // decode-side driver: stimulus pushes expectations
  initial begin
    bit r, src, flt;
    logic [31:0] tgt, nxt;
    b0.instr_ready   = 0;
    b0.pc_src        = 0;
    b0.branch_target = 0;
    forever begin
      step();
      if (rst0) begin
        b0.instr_ready = 0;
      end else begin
        r   = ($urandom_range(0, 2) != 0);
        src = ($urandom_range(0, 3) == 0);
        tgt = $urandom & 32'hFFFF_FFFC;
        if (allow_fault && src
            && $urandom_range(0, 7) == 0)
          tgt = tgt | 32'($urandom_range(1, 3));
        b0.instr_ready   = r;
        b0.pc_src        = src;
        b0.branch_target = tgt;
        if (b0.instr_valid && r) begin
          flt = src && (tgt[1:0] != 2'b00);
          nxt = src ? tgt : model_pc + 32'd4;
          fault_q.push_back(flt);
          if (!flt) begin
            model_pc = nxt;
            req_q.push_back(nxt);
            ins_q.push_back('{nxt, mem_word(nxt)});
          end
        end
      end
    end
  end

  // monitor for u0
  bit   rst_prev = 0;
  bit   mon_out = 0;
  bit   resp_pend = 0;
  bit   cons_prev = 0;
  always @(negedge clk) begin
    exp_t e;
    logic [31:0] a;
    bit f;
    chk("req_in_reset_or_fault",
        b0.imem_req_valid,
        (rst0 || model_fault) ? 0 : b0.imem_req_valid);
    if (rst0) begin
      if (rst_prev) begin
        chk("rst_pc", b0.pc, RV0);
        chk("rst_instr", b0.instr, 32'h13);
        chk("rst_fields",
            {b0.funct7, b0.rs2, b0.rs1,
             b0.funct3, b0.rd, b0.opcode}, 32'h13);
        chk("rst_valid", b0.instr_valid, 0);
        chk("rst_fault", b0.fetch_fault, 0);
      end
      mon_out = 0;
      resp_pend = 0;
      cons_prev = 0;
    end else begin
      chk("fetch_fault", b0.fetch_fault, model_fault);
      if (cons_prev)
        chk("req_after_consume",
            b0.imem_req_valid, !model_fault);
      if (resp_pend)
        chk("valid_after_resp", b0.instr_valid, 1);
      resp_pend = b0.imem_resp_valid && mon_out;
      if (resp_pend) mon_out = 0;
      if (b0.imem_req_valid && b0.imem_req_ready) begin
        chk("req_expected", req_q.size() != 0, 1);
        if (req_q.size() != 0) begin
          a = req_q.pop_front();
          chk("imem_addr", b0.imem_addr, a);
          chk("pc_eq_addr", b0.pc, a);
        end
        mon_out = 1;
      end
      cons_prev = b0.instr_valid && b0.instr_ready;
      if (cons_prev) begin
        chk("instr_expected",
            ins_q.size() != 0 && fault_q.size() != 0, 1);
        if (ins_q.size() != 0 && fault_q.size() != 0) begin
          e = ins_q.pop_front();
          f = fault_q.pop_front();
          delivered++;
          chk("pc", b0.pc, e.pc);
          chk("instr", b0.instr, e.word);
          chk("pc_plus4", b0.pc_plus4, e.pc + 32'd4);
          chk("fields",
              {b0.funct7, b0.rs2, b0.rs1,
               b0.funct3, b0.rd, b0.opcode}, e.word);
          if (f) model_fault = 1;
        end
      end
    end
    rst_prev = rst0;
  end

  task automatic release0();
    step();
    req_q.delete();
    ins_q.delete();
    fault_q.delete();
    model_pc    = RV0;
    model_fault = 0;
    req_q.push_back(RV0);
    ins_q.push_back('{RV0, mem_word(RV0)});
    rst0 = 0;
  endtask

  initial begin
    bit found;
    rst0 = 1;
    rst1 = 1;
    model_fault = 0;
    model_pc = RV0;
    b1.imem_req_ready  = 0;
    b1.imem_resp_valid = 0;
    b1.imem_rdata      = 0;
    b1.instr_ready     = 0;
    b1.pc_src          = 0;
    b1.branch_target   = 0;
    repeat (2) step();
    @(negedge clk);
    chk("u1_rst_req", b1.imem_req_valid, 0);
    chk("u1_rst_pc", b1.pc, RV1);
    chk("u1_rst_instr", b1.instr, 32'h13);
    chk("u1_rst_opcode", 32'(b1.opcode), 32'h13);
    chk("u1_rst_valid", b1.instr_valid, 0);

    // first fetch from the top of the address space
    step();
    rst1 = 0;
    b1.imem_req_ready = 1;
    @(negedge clk);
    chk("u1_req1_valid", b1.imem_req_valid, 1);
    chk("u1_req1_addr", b1.imem_addr, RV1);
    step();
    b1.imem_req_ready  = 0;
    b1.imem_resp_valid = 1;
    b1.imem_rdata      = 32'h0050_0093;
    @(negedge clk);
    chk("u1_wait_req", b1.imem_req_valid, 0);
    chk("u1_wait_valid", b1.instr_valid, 0);
    step();
    b1.imem_resp_valid = 0;
    @(negedge clk);
    chk("u1_valid_c3", b1.instr_valid, 1);
    chk("u1_opcode", 32'(b1.opcode), 32'h13);
    chk("u1_rd", 32'(b1.rd), 1);
    chk("u1_rs1", 32'(b1.rs1), 0);
    chk("u1_funct3", 32'(b1.funct3), 0);
    chk("u1_pc", b1.pc, RV1);
    chk("u1_pc_plus4_wrap", b1.pc_plus4, 0);
    b1.instr_ready = 1;
    b1.pc_src      = 0;
    step();
    b1.instr_ready    = 0;
    b1.imem_req_ready = 1;
    @(negedge clk);
    chk("u1_wrap_req", b1.imem_req_valid, 1);
    chk("u1_wrap_addr", b1.imem_addr, 0);
    chk("u1_wrap_fault", b1.fetch_fault, 0);

    // branch to 0x40
    step();
    b1.imem_req_ready  = 0;
    b1.imem_resp_valid = 1;
    b1.imem_rdata      = 32'h0400_006F;
    step();
    b1.imem_resp_valid = 0;
    @(negedge clk);
    chk("u1_hold2", b1.instr_valid, 1);
    b1.instr_ready   = 1;
    b1.pc_src        = 1;
    b1.branch_target = 32'h40;
    step();
    b1.instr_ready    = 0;
    b1.pc_src         = 0;
    b1.imem_req_ready = 1;
    @(negedge clk);
    chk("u1_br_req", b1.imem_req_valid, 1);
    chk("u1_br_addr", b1.imem_addr, 32'h40);

    // misaligned target 0x42 freezes the stage
    step();
    b1.imem_req_ready  = 0;
    b1.imem_resp_valid = 1;
    b1.imem_rdata      = 32'h0000_0013;
    step();
    b1.imem_resp_valid = 0;
    @(negedge clk);
    chk("u1_hold3", b1.instr_valid, 1);
    b1.instr_ready   = 1;
    b1.pc_src        = 1;
    b1.branch_target = 32'h42;
    step();
    b1.instr_ready     = 0;
    b1.pc_src          = 0;
    b1.imem_req_ready  = 1;
    b1.imem_resp_valid = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("u1_fault", b1.fetch_fault, 1);
      chk("u1_fault_req", b1.imem_req_valid, 0);
      chk("u1_fault_valid", b1.instr_valid, 0);
      chk("u1_fault_pc", b1.pc, 32'h40);
      step();
    end
    b1.imem_req_ready  = 0;
    b1.imem_resp_valid = 0;

    // randomized run on u0
    release0();
    repeat (1500) step();

    // reset while a request is in flight
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      found = b0.imem_req_valid && b0.imem_req_ready;
    end
    chk("wait_accept", found, 1);
    step();
    rst0 = 1;
    repeat (2) step();
    release0();
    @(negedge clk);
    chk("post_rst_req", b0.imem_req_valid, 1);
    chk("post_rst_addr", b0.imem_addr, RV0);
    chk("post_rst_valid", b0.instr_valid, 0);
    repeat (1500) step();

    allow_fault = 1;
    repeat (600) step();
    chk("delivered_enough", delivered > 50, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
